// File: rtl/mem_wb_stage.sv
// MEM access + WB pipeline register for the 5-stage CPU.
// Drives the data-memory request/response handshake, aligns and extends load
// data, and produces a registered regfile write port (rf_load/rf_dest/rf_in).
// Optional feature macro: MISALIGN_TRAP_EN (misaligned accesses trap instead
// of issuing a memory request). Without it, trap is tied low.
module mem_wb_stage #(
  parameter int unsigned     XLEN   = 32,
  parameter logic [XLEN-1:0] RESETV = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_alu_out,
  input  logic [XLEN-1:0] in_pc,
  input  logic [1:0]      in_wb_sel,
  input  logic            in_mem_read,
  input  logic            in_mem_write,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic            dmem_resp,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall,
  output logic            dmem_read,
  output logic            dmem_write,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wmask,
  output logic            rf_load,
  output logic [4:0]      rf_dest,
  output logic [XLEN-1:0] rf_in,
  output logic            trap
);

  localparam logic [XLEN-1:0] PcStep = XLEN'(4);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e      state_q;
  logic [1:0]  off_q;      // byte offset of the outstanding access
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;
  logic        is_load_q;

  logic            mem_op;
  logic            misalign;
  logic [XLEN-1:0] wb_data;
  logic [3:0]      st_mask;
  logic [XLEN-1:0] st_wdata;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;

  // Writeback source select for non-memory instructions (1 and 3 fall back to ALU).
  always_comb begin
    wb_data = in_alu_out;
    if (in_wb_sel == 2'd2) begin
      wb_data = in_pc + PcStep;
    end
  end

  // Store byte lanes and replicated store data.
  always_comb begin
    st_mask  = 4'b1111;
    st_wdata = in_rs2_data;
    case (in_funct3[1:0])
      2'b00: begin
        st_mask  = 4'b0001 << in_alu_out[1:0];
        st_wdata = {4{in_rs2_data[7:0]}};
      end
      2'b01: begin
        st_mask  = 4'b0011 << {in_alu_out[1], 1'b0};
        st_wdata = {2{in_rs2_data[15:0]}};
      end
      default: begin
        st_mask  = 4'b1111;
        st_wdata = in_rs2_data;
      end
    endcase
  end

  // Misalignment detection; h needs addr[0]==0, w needs addr[1:0]==0.
  always_comb begin
    mem_op   = in_mem_read | in_mem_write;
    misalign = 1'b0;
`ifdef MISALIGN_TRAP_EN
    case (in_funct3[1:0])
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = in_alu_out[0];
      default: misalign = |in_alu_out[1:0];
    endcase
`endif
  end

  // Load data alignment and sign/zero extension from the latched offset.
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  // FSM, memory request registers and WB register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      off_q      <= 2'd0;
      funct3_q   <= 3'd0;
      rd_q       <= 5'd0;
      is_load_q  <= 1'b0;
      stall      <= 1'b0;
      dmem_read  <= 1'b0;
      dmem_write <= 1'b0;
      dmem_addr  <= RESETV;
      dmem_wdata <= RESETV;
      dmem_wmask <= 4'b0000;
      rf_load    <= 1'b0;
      rf_dest    <= 5'd0;
      rf_in      <= RESETV;
`ifdef MISALIGN_TRAP_EN
      trap       <= 1'b0;
`endif
    end else begin
      rf_load <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      trap    <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            if (mem_op) begin
              if (misalign) begin
`ifdef MISALIGN_TRAP_EN
                trap <= 1'b1;
`endif
              end else begin
                state_q    <= StWait;
                stall      <= 1'b1;
                // Read wins when both are set; no store is issued.
                dmem_read  <= in_mem_read;
                dmem_write <= ~in_mem_read;
                dmem_addr  <= {in_alu_out[XLEN-1:2], 2'b00};
                dmem_wdata <= st_wdata;
                dmem_wmask <= in_mem_read ? 4'b0000 : st_mask;
                off_q      <= in_alu_out[1:0];
                funct3_q   <= in_funct3;
                rd_q       <= in_rd;
                is_load_q  <= in_mem_read;
              end
            end else begin
              rf_load <= (in_rd != 5'd0);
              rf_dest <= in_rd;
              rf_in   <= wb_data;
            end
          end
        end
        StWait: begin
          if (dmem_resp) begin
            state_q    <= StIdle;
            stall      <= 1'b0;
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            if (is_load_q) begin
              rf_load <= (rd_q != 5'd0);
              rf_dest <= rd_q;
              rf_in   <= ld_data;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifndef MISALIGN_TRAP_EN
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage with hand-computed expectations.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [4:0]  in_rd;
  logic [31:0] in_alu_out;
  logic [31:0] in_pc;
  logic [1:0]  in_wb_sel;
  logic        in_mem_read;
  logic        in_mem_write;
  logic [2:0]  in_funct3;
  logic [31:0] in_rs2_data;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wmask;
  logic        rf_load;
  logic [4:0]  rf_dest;
  logic [31:0] rf_in;
  logic        trap;

  int checks;
  int errors;

  mem_wb_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_rd        (in_rd),
    .in_alu_out   (in_alu_out),
    .in_pc        (in_pc),
    .in_wb_sel    (in_wb_sel),
    .in_mem_read  (in_mem_read),
    .in_mem_write (in_mem_write),
    .in_funct3    (in_funct3),
    .in_rs2_data  (in_rs2_data),
    .dmem_resp    (dmem_resp),
    .dmem_rdata   (dmem_rdata),
    .stall        (stall),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_wmask   (dmem_wmask),
    .rf_load      (rf_load),
    .rf_dest      (rf_dest),
    .rf_in        (rf_in),
    .trap         (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs and samples both sit 1ns after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] pc, input logic [1:0] sel, input logic mr,
                       input logic mw, input logic [2:0] f3, input logic [31:0] rs2);
    in_valid     = v;
    in_rd        = rd;
    in_alu_out   = alu;
    in_pc        = pc;
    in_wb_sel    = sel;
    in_mem_read  = mr;
    in_mem_write = mw;
    in_funct3    = f3;
    in_rs2_data  = rs2;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 3'd0, 32'h0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    dmem_resp  = 1'b0;
    dmem_rdata = 32'h0;
    idle();
    cycle();
    cycle();

    // Reset state
    check("rst_stall", stall, 0);
    check("rst_dmem_read", dmem_read, 0);
    check("rst_dmem_write", dmem_write, 0);
    check("rst_dmem_addr", dmem_addr, 0);
    check("rst_dmem_wdata", dmem_wdata, 0);
    check("rst_dmem_wmask", dmem_wmask, 0);
    check("rst_rf_load", rf_load, 0);
    check("rst_rf_dest", rf_dest, 0);
    check("rst_rf_in", rf_in, 0);
    check("rst_trap", trap, 0);
    rst = 1'b0;

    // ALU writeback, then back-to-back PC+4 writeback
    drive(1'b1, 5'd5, 32'h1234, 32'h0, 2'd0, 1'b0, 1'b0, 3'd0, 32'h0);
    cycle();
    check("alu_rf_load", rf_load, 1);
    check("alu_rf_dest", rf_dest, 5);
    check("alu_rf_in", rf_in, 32'h1234);
    check("alu_stall", stall, 0);
    drive(1'b1, 5'd7, 32'h55, 32'h100, 2'd2, 1'b0, 1'b0, 3'd0, 32'h0);
    cycle();
    check("pc4_rf_load", rf_load, 1);
    check("pc4_rf_dest", rf_dest, 7);
    check("pc4_rf_in", rf_in, 32'h104);
    idle();
    cycle();
    check("pulse_rf_load", rf_load, 0);

    // lb at 0x103, response 3 cycles after the request
    drive(1'b1, 5'd9, 32'h103, 32'h0, 2'd0, 1'b1, 1'b0, 3'b000, 32'h0);
    cycle();
    idle();
    check("lb_stall1", stall, 1);
    check("lb_dmem_read", dmem_read, 1);
    check("lb_dmem_write", dmem_write, 0);
    check("lb_dmem_addr", dmem_addr, 32'h100);
    cycle();
    check("lb_stall2", stall, 1);
    cycle();
    check("lb_stall3", stall, 1);
    check("lb_read_held", dmem_read, 1);
    check("lb_rf_load_wait", rf_load, 0);
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h80FF_FFFF;
    cycle();
    dmem_resp = 1'b0;
    check("lb_stall_done", stall, 0);
    check("lb_read_drop", dmem_read, 0);
    check("lb_rf_load", rf_load, 1);
    check("lb_rf_dest", rf_dest, 9);
    check("lb_rf_in", rf_in, 32'hFFFF_FF80);
    cycle();
    check("lb_rf_load_pulse", rf_load, 0);

    // lhu at 0x102, immediate response: upper half zero-extended
    drive(1'b1, 5'd10, 32'h102, 32'h0, 2'd0, 1'b1, 1'b0, 3'b101, 32'h0);
    cycle();
    idle();
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h8001_1234;
    cycle();
    dmem_resp = 1'b0;
    check("lhu_rf_in", rf_in, 32'h0000_8001);
    check("lhu_rf_load", rf_load, 1);

    // sh at 0x22
    drive(1'b1, 5'd3, 32'h22, 32'h0, 2'd0, 1'b0, 1'b1, 3'b001, 32'h0000_ABCD);
    cycle();
    idle();
    check("sh_dmem_write", dmem_write, 1);
    check("sh_dmem_read", dmem_read, 0);
    check("sh_dmem_addr", dmem_addr, 32'h20);
    check("sh_wmask", dmem_wmask, 4'b1100);
    check("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    dmem_resp = 1'b1;
    cycle();
    dmem_resp = 1'b0;
    check("sh_write_drop", dmem_write, 0);
    check("sh_rf_load", rf_load, 0);
    check("sh_stall", stall, 0);

    // sb at 0x41
    drive(1'b1, 5'd3, 32'h41, 32'h0, 2'd0, 1'b0, 1'b1, 3'b000, 32'h1234_565A);
    cycle();
    idle();
    check("sb_wmask", dmem_wmask, 4'b0010);
    check("sb_wdata", dmem_wdata, 32'h5A5A_5A5A);
    dmem_resp = 1'b1;
    cycle();
    dmem_resp = 1'b0;
    check("sb_rf_load", rf_load, 0);

    // rd=0 suppresses the write; PC+4 wraps to 0
    drive(1'b1, 5'd0, 32'h0, 32'hFFFF_FFFC, 2'd2, 1'b0, 1'b0, 3'd0, 32'h0);
    cycle();
    check("rd0_rf_load", rf_load, 0);
    drive(1'b1, 5'd1, 32'h0, 32'hFFFF_FFFC, 2'd2, 1'b0, 1'b0, 3'd0, 32'h0);
    cycle();
    idle();
    check("wrap_rf_load", rf_load, 1);
    check("wrap_rf_in", rf_in, 32'h0);

    // Response while idle is ignored
    dmem_resp = 1'b1;
    cycle();
    dmem_resp = 1'b0;
    check("idle_resp_stall", stall, 0);
    check("idle_resp_rf_load", rf_load, 0);
    check("idle_resp_read", dmem_read, 0);

    // Read and write both set: treated as lw
    drive(1'b1, 5'd12, 32'h80, 32'h0, 2'd0, 1'b1, 1'b1, 3'b010, 32'h0);
    cycle();
    idle();
    check("rw_dmem_read", dmem_read, 1);
    check("rw_dmem_write", dmem_write, 0);
    dmem_resp  = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    cycle();
    dmem_resp = 1'b0;
    check("rw_rf_in", rf_in, 32'hDEAD_BEEF);
    check("rw_rf_dest", rf_dest, 12);

    // Reset mid-WAIT, then a late response
    drive(1'b1, 5'd4, 32'h200, 32'h0, 2'd0, 1'b1, 1'b0, 3'b010, 32'h0);
    cycle();
    idle();
    check("rstw_read", dmem_read, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rstw_read_drop", dmem_read, 0);
    check("rstw_stall", stall, 0);
    dmem_resp = 1'b1;
    cycle();
    dmem_resp = 1'b0;
    check("rstw_late_rf_load", rf_load, 0);
    check("rstw_late_stall", stall, 0);
    check("rstw_late_read", dmem_read, 0);

    // lw at addr 0x2
    drive(1'b1, 5'd6, 32'h2, 32'h0, 2'd0, 1'b1, 1'b0, 3'b010, 32'h0);
    cycle();
    idle();
`ifdef MISALIGN_TRAP_EN
    check("mis_trap", trap, 1);
    check("mis_dmem_read", dmem_read, 0);
    check("mis_stall", stall, 0);
    check("mis_rf_load", rf_load, 0);
    cycle();
    check("mis_trap_pulse", trap, 0);
    check("mis_rf_load2", rf_load, 0);
`else
    check("mis_trap", trap, 0);
    check("mis_dmem_read", dmem_read, 1);
    check("mis_dmem_addr", dmem_addr, 32'h0);
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h1122_3344;
    cycle();
    dmem_resp = 1'b0;
    check("mis_rf_in", rf_in, 32'h1122_3344);
    check("mis_rf_load", rf_load, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
